// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue front end: widths, legal opcodes,
// sequencer states and RV32I field-slice helpers.
package alu_pkg;

  localparam int unsigned DW = 32;
  localparam int unsigned IW = 32;

  localparam logic [6:0] OPC_R = 7'h33;
  localparam logic [6:0] OPC_I = 7'h13;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    WB,
    HALT
  } state_t;

  function automatic logic [6:0] opcode_of(input logic [31:0] inst);
    return inst[6:0];
  endfunction

  function automatic logic [4:0] rd_of(input logic [31:0] inst);
    return inst[11:7];
  endfunction

  function automatic logic [4:0] rs1_of(input logic [31:0] inst);
    return inst[19:15];
  endfunction

  function automatic logic [4:0] rs2_of(input logic [31:0] inst);
    return inst[24:20];
  endfunction

endpackage

// File: rtl/issue_regfile.sv
// 32-entry register file: two operand read ports and one debug read port
// (all asynchronous), one synchronous write port, x0 hardwired to zero.
module issue_regfile #(
  parameter int unsigned DW = alu_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    raddr1,
  output logic [DW-1:0] rdata1,
  input  logic [4:0]    raddr2,
  output logic [DW-1:0] rdata2,
  input  logic [4:0]    dbg_raddr,
  output logic [DW-1:0] dbg_rdata,
  input  logic          we,
  input  logic [4:0]    waddr,
  input  logic [DW-1:0] wdata
);

  logic [DW-1:0] mem [0:31];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) mem[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1    = (raddr1    == 5'd0) ? '0 : mem[raddr1];
  assign rdata2    = (raddr2    == 5'd0) ? '0 : mem[raddr2];
  assign dbg_rdata = (dbg_raddr == 5'd0) ? '0 : mem[dbg_raddr];

endmodule

// File: rtl/alu_issue.sv
// Non-overlapped fetch/decode/exec/writeback sequencer feeding a
// combinational ALU from an internal register file.
module alu_issue #(
  parameter int unsigned DW   = alu_pkg::DW,
  parameter int unsigned IW   = alu_pkg::IW,
  parameter int unsigned PC_W = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [IW-1:0]   imem_rdata,
  output logic [DW-1:0]   alu_r1,
  output logic [DW-1:0]   alu_r2,
  output logic [IW-1:0]   alu_inst,
  input  logic [DW-1:0]   alu_res,
  output logic            halt,
  output logic [31:0]     retired,
  input  logic [4:0]      dbg_raddr,
  output logic [DW-1:0]   dbg_rdata
);

  import alu_pkg::*;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc;
  logic [IW-1:0]   inst;
  logic [DW-1:0]   res;
  logic [DW-1:0]   rf_rdata1, rf_rdata2;
  logic            legal;

  assign legal = (opcode_of(inst) == OPC_R) || (opcode_of(inst) == OPC_I);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = FETCH;
      FETCH:   if (imem_ack) state_nxt = DECODE;
      DECODE:  state_nxt = legal ? EXEC : HALT;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = FETCH;
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // Both outputs decode from the state register only.
  assign imem_req  = (state == FETCH);
  assign halt      = (state == HALT);
  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      inst     <= '0;
      alu_r1   <= '0;
      alu_r2   <= '0;
      alu_inst <= '0;
      res      <= '0;
      retired  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        FETCH:  if (imem_ack) inst <= imem_rdata;
        DECODE: if (legal) begin
          alu_r1   <= rf_rdata1;
          alu_r2   <= rf_rdata2;
          alu_inst <= inst;
        end
        EXEC:   res <= alu_res;
        WB: begin
          pc      <= pc + PC_W'(1);
          retired <= retired + 32'd1;
        end
        default: ;
      endcase
    end
  end

  issue_regfile #(.DW(DW)) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .raddr1    (rs1_of(inst)),
    .rdata1    (rf_rdata1),
    .raddr2    (rs2_of(inst)),
    .rdata2    (rf_rdata2),
    .dbg_raddr (dbg_raddr),
    .dbg_rdata (dbg_rdata),
    .we        (state == WB),
    .waddr     (rd_of(inst)),
    .wdata     (res)
  );

endmodule

// File: tb/tb_alu_issue.sv
// Randomized scoreboard bench for alu_issue: an ISA-level model predicts each
// retirement when the fetch is acknowledged; a monitor checks it on retirement.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] alu_r1, alu_r2, alu_inst, alu_res;
  logic        halt;
  logic [31:0] retired;
  logic [4:0]  dbg_raddr = 5'd0;
  logic [31:0] dbg_rdata;

  always #50 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RV32I register-register / register-immediate semantics.
  function automatic logic [31:0] rv_op(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] inst);
    logic [31:0] op2;
    logic [4:0]  sh;
    op2 = (inst[6:0] == 7'h13) ? {{20{inst[31]}}, inst[31:20]} : b;
    sh  = op2[4:0];
    case (inst[14:12])
      3'd0:    rv_op = (inst[6:0] == 7'h33 && inst[30]) ? a - op2 : a + op2;
      3'd1:    rv_op = a << sh;
      3'd2:    rv_op = ($signed(a) < $signed(op2)) ? 32'd1 : 32'd0;
      3'd3:    rv_op = (a < op2) ? 32'd1 : 32'd0;
      3'd4:    rv_op = a ^ op2;
      3'd5:    rv_op = inst[30] ? $unsigned($signed(a) >>> sh) : a >> sh;
      3'd6:    rv_op = a | op2;
      default: rv_op = a & op2;
    endcase
  endfunction

  assign alu_res = rv_op(alu_r1, alu_r2, alu_inst);

  alu_issue #(.DW(32), .IW(32), .PC_W(8), .RESET_PC(8'd0)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .alu_r1     (alu_r1),
    .alu_r2     (alu_r2),
    .alu_inst   (alu_inst),
    .alu_res    (alu_res),
    .halt       (halt),
    .retired    (retired),
    .dbg_raddr  (dbg_raddr),
    .dbg_rdata  (dbg_rdata)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
    logic [31:0] old;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] inst;
    logic [31:0] ret;
    int          ack_cyc;
  } exp_t;

  exp_t sbq[$];

  // Reference machine state
  logic [31:0] prog [256];
  logic [31:0] xm [32];
  logic [7:0]  m_pc;
  logic [31:0] m_count;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) xm[i] = 32'd0;
    m_pc    = 8'd0;
    m_count = 32'd0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] imm;
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    f3  = 3'($urandom_range(0, 7));
    if ($urandom_range(0, 1) == 1) begin
      f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      return {f7, rs2, rs1, f3, rd, 7'h33};
    end
    imm = 12'($urandom);
    if (f3 == 3'd1) imm[11:5] = 7'h00;
    if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return {imm, rs1, f3, rd, 7'h13};
  endfunction

  // Memory responder and stimulus: serves n fetches; with abort set, the last
  // fetch is left unacknowledged for two cycles and reset is asserted.
  task automatic serve(input int n, input bit directed, input bit abort);
    int          t;
    int          waits;
    logic [31:0] word;
    logic [31:0] v;
    exp_t        e;
    for (int k = 0; k < n; k++) begin
      t = 0;
      while (!imem_req && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (!imem_req) begin
        chk("fetch_req_timeout", {31'd0, imem_req}, 32'd1);
        return;
      end
      chk("fetch_addr", {24'd0, imem_addr}, {24'd0, m_pc});
      if (abort && k == n - 1) begin
        repeat (2) begin
          imem_ack   = 1'b0;
          imem_rdata = $urandom;
          @(negedge clk);
          chk("abort_req_held", {31'd0, imem_req}, 32'd1);
        end
        rst = 1'b1;
        return;
      end
      if (directed && m_pc == 8'd3) waits = 3;
      else if (directed && m_pc < 8'd3) waits = 0;
      else waits = $urandom_range(0, 3);
      for (int w = 0; w < waits; w++) begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        @(negedge clk);
        chk("wait_req_held", {31'd0, imem_req}, 32'd1);
        chk("wait_addr_held", {24'd0, imem_addr}, {24'd0, m_pc});
      end
      word       = prog[m_pc];
      imem_ack   = 1'b1;
      imem_rdata = word;
      if (word[6:0] != 7'h33 && word[6:0] != 7'h13) begin
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        chk("halt_in_decode", {31'd0, halt}, 32'd0);
        @(negedge clk);
        chk("halt_after_decode", {31'd0, halt}, 32'd1);
        chk("halt_req_low", {31'd0, imem_req}, 32'd0);
        repeat (4) @(negedge clk);
        chk("halt_sticky", {31'd0, halt}, 32'd1);
        chk("halt_req_stays_low", {31'd0, imem_req}, 32'd0);
        chk("halt_retired", retired, m_count);
        return;
      end
      e.inst    = word;
      e.rd      = word[11:7];
      e.r1      = xm[word[19:15]];
      e.r2      = xm[word[24:20]];
      e.old     = xm[word[11:7]];
      v         = rv_op(e.r1, e.r2, word);
      if (e.rd != 5'd0) xm[e.rd] = v;
      e.val     = xm[e.rd];
      m_count   = m_count + 32'd1;
      e.ret     = m_count;
      e.ack_cyc = cyc + 1;
      m_pc      = m_pc + 8'd1;
      sbq.push_back(e);
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
    end
  endtask

  // Monitor: register-file clear under reset, old value during WB,
  // full retirement check when the retired count moves.
  logic [31:0] prev_ret = 32'd0;
  always @(negedge clk) begin
    int   bad;
    exp_t e;
    if (rst) begin
      prev_ret = 32'd0;
      bad = 0;
      for (int i = 0; i < 32; i++) begin
        dbg_raddr = 5'(i);
        #1;
        if (dbg_rdata !== 32'd0) bad++;
      end
      chk("reset_regs_zero", 32'(bad), 32'd0);
    end else begin
      if (sbq.size() > 0 && cyc == sbq[0].ack_cyc + 2) begin
        dbg_raddr = sbq[0].rd;
        #1;
        chk("wb_old_value", dbg_rdata, sbq[0].old);
      end
      if (retired !== prev_ret) begin
        prev_ret = retired;
        if (sbq.size() == 0) begin
          chk("unexpected_retire", retired, m_count);
        end else begin
          e = sbq.pop_front();
          chk("retired", retired, e.ret);
          chk("retire_cycle", 32'(cyc), 32'(e.ack_cyc + 3));
          chk("alu_inst", alu_inst, e.inst);
          chk("alu_r1", alu_r1, e.r1);
          chk("alu_r2", alu_r2, e.r2);
          chk("no_halt", {31'd0, halt}, 32'd0);
          dbg_raddr = e.rd;
          #1;
          chk("rd_value", dbg_rdata, e.val);
        end
      end
    end
  end

  initial begin
    int t;
    rst        = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    for (int i = 0; i < 256; i++) prog[i] = rand_inst();
    prog[0]  = 32'h00500093;
    prog[1]  = 32'h00700113;
    prog[2]  = 32'h002081B3;
    prog[3]  = 32'h00900013;
    prog[40] = 32'h00000073;
    model_reset();

    repeat (3) begin
      @(negedge clk);
      chk("reset_req", {31'd0, imem_req}, 32'd0);
      chk("reset_halt", {31'd0, halt}, 32'd0);
      chk("reset_retired", retired, 32'd0);
    end
    rst = 1'b0;
    #1 chk("idle_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    serve(41, 1'b1, 1'b0);

    // Fresh start after halt, then reset in the middle of a fetch.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset_clears_halt", {31'd0, halt}, 32'd0);
    chk("reset_req_after_halt", {31'd0, imem_req}, 32'd0);
    model_reset();
    for (int i = 0; i < 256; i++) prog[i] = rand_inst();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("idle_req_2", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    serve(7, 1'b0, 1'b1);
    #1;
    chk("abort_req_drops", {31'd0, imem_req}, 32'd0);
    chk("abort_no_pending", 32'(sbq.size()), 32'd0);
    model_reset();
    repeat (2) begin
      @(negedge clk);
      chk("abort_retired_clear", retired, 32'd0);
      chk("abort_alu_inst_clear", alu_inst, 32'd0);
    end
    rst = 1'b0;
    #1 chk("idle_req_3", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    serve(5, 1'b0, 1'b0);

    t = 0;
    while (sbq.size() > 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
